// File: rtl/lock_seq_ctrl.sv
// Sequencer that stores {a,b} symbols and replays them into a lock checker,
// re-resetting and replaying on checker error up to MAX_RETRY times.
module lock_seq_ctrl #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int MAX_RETRY = 3,
  parameter int RW        = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [1:0]    wr_sym,
  output logic          wr_ready,
  input  logic          clr,
  input  logic          start,
  output logic          chk_rst,
  output logic          chk_a,
  output logic          chk_b,
  output logic          chk_valid,
  input  logic          chk_err,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [RW-1:0] retries,
  output logic [AW:0]   len
);

  typedef enum logic [2:0] {IDLE, RST, ISSUE, RETRY, DONE} state_t;

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] idx;
  logic [RW-1:0] retry_cnt;
  logic          not_full;
  logic          accept_wr;
  logic [AW:0]   run_len;
  logic          last_sym;

  assign not_full  = (len < (AW+1)'(DEPTH));
  assign wr_ready  = (state == IDLE) && not_full;
  assign accept_wr = wr_ready && wr_en && !clr;

  // Length the run will actually use: clr empties, a same-cycle write is included.
  assign run_len   = clr ? '0 : (len + {{AW{1'b0}}, accept_wr});
  assign last_sym  = ({1'b0, idx} == (len - 1'b1));

  always_ff @(posedge clk) begin
    if (accept_wr) begin
      mem[len[AW-1:0]] <= wr_sym;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len       <= '0;
      idx       <= '0;
      retry_cnt <= '0;
      pass      <= 1'b0;
      retries   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            len <= '0;
          end else if (accept_wr) begin
            len <= len + 1'b1;
          end
          if (start) begin
            pass      <= 1'b0;
            retries   <= '0;
            retry_cnt <= '0;
            idx       <= '0;
            state     <= (run_len == '0) ? DONE : RST;
          end
        end
        RST: begin
          idx   <= '0;
          state <= ISSUE;
        end
        ISSUE: begin
          if (chk_err) begin
            state <= RETRY;
          end else if (last_sym) begin
            pass    <= 1'b1;
            retries <= retry_cnt;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RETRY: begin
          if (retry_cnt == RW'(MAX_RETRY)) begin
            pass    <= 1'b0;
            retries <= retry_cnt;
            state   <= DONE;
          end else begin
            retry_cnt <= retry_cnt + 1'b1;
            state     <= RST;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Checker drive is decoded from the registered state, so it is glitch-free.
  assign chk_valid = (state == ISSUE);
  assign chk_a     = chk_valid & mem[idx][1];
  assign chk_b     = chk_valid & mem[idx][0];
  assign chk_rst   = reset | (state == RST);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed bench for lock_seq_ctrl: stimulus pushes expected run results,
// a monitor pops and checks them on every done pulse.
module tb_lock_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_sym;
  logic       wr_ready;
  logic       clr;
  logic       start;
  logic       chk_rst;
  logic       chk_a;
  logic       chk_b;
  logic       chk_valid;
  logic       chk_err;
  logic       busy;
  logic       done;
  logic       pass;
  logic [1:0] retries;
  logic [3:0] len;

  lock_seq_ctrl dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sym(wr_sym), .wr_ready(wr_ready),
    .clr(clr), .start(start), .chk_rst(chk_rst), .chk_a(chk_a), .chk_b(chk_b),
    .chk_valid(chk_valid), .chk_err(chk_err), .busy(busy), .done(done),
    .pass(pass), .retries(retries), .len(len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int pass;
    int retries;
    int rsts;
    int syms;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   att_cnt = 0;
  int   sym_idx = 0;
  int   issued  = 0;
  int   mode    = 0;
  logic cnt_clr = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural checker stand-in: counts attempts/symbols and raises error by mode.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_clr) begin
      att_cnt <= 0;
      sym_idx <= 0;
      issued  <= 0;
    end else if (!reset) begin
      if (chk_rst) begin
        att_cnt <= att_cnt + 1;
        sym_idx <= 0;
      end else if (chk_valid) begin
        sym_idx <= sym_idx + 1;
        issued  <= issued + 1;
      end
    end
  end

  always_comb begin
    chk_err = 1'b0;
    if (chk_valid) begin
      if (mode == 1 && att_cnt == 1 && sym_idx == 2) chk_err = 1'b1;
      if (mode == 2 && sym_idx == 1) chk_err = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("pass", int'(pass), e.pass);
        chk("retries", int'(retries), e.retries);
        chk("chk_rst_pulses", att_cnt, e.rsts);
        chk("symbols_issued", issued, e.syms);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s);
    wr_en  = 1'b1;
    wr_sym = s;
    step();
    wr_en  = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // dcyc is the done cycle relative to the cycle in which start is presented.
  task automatic run(input int dcyc, input int p, input int r, input int rs,
                     input int sy, input logic with_wr, input logic [1:0] s,
                     input logic expect_done);
    exp_t x;
    x.cyc = cyc + dcyc; x.pass = p; x.retries = r; x.rsts = rs; x.syms = sy;
    if (expect_done) q.push_back(x);
    start   = 1'b1;
    cnt_clr = 1'b1;
    if (with_wr) begin
      wr_en  = 1'b1;
      wr_sym = s;
    end
    step();
    start   = 1'b0;
    cnt_clr = 1'b0;
    wr_en   = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      step();
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    step();
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_sym = 2'b00; clr = 1'b0; start = 1'b0;
    step();
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_retries", int'(retries), 0);
    chk("rst_len", int'(len), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_chk_valid", int'(chk_valid), 0);
    chk("rst_chk_rst", int'(chk_rst), 1);
    step();
    reset = 1'b0;
    step();

    // Clean run of 11,01,00,00
    mode = 0;
    wr(2'b11); wr(2'b01); wr(2'b00); wr(2'b00);
    run(6, 1, 0, 1, 4, 1'b0, 2'b00, 1'b1);
    @(negedge clk);
    chk("busy_during_run", int'(busy), 1);
    chk("wr_ready_during_run", int'(wr_ready), 0);
    wait_done();

    // Stored sequence reused; single error on symbol 2 of attempt 1
    mode = 1;
    run(11, 1, 1, 2, 7, 1'b0, 2'b00, 1'b1);
    wait_done();

    // Error on last symbol every attempt -> exhausted
    mode = 2;
    do_clr();
    wr(2'b11); wr(2'b11);
    run(17, 0, 3, 4, 8, 1'b0, 2'b00, 1'b1);
    wait_done();
    mode = 0;

    // Fill beyond DEPTH
    do_clr();
    for (int i = 0; i < 8; i++) wr(2'(i));
    @(negedge clk);
    chk("full_len", int'(len), 8);
    chk("full_wr_ready", int'(wr_ready), 0);
    step();
    wr(2'b10);
    @(negedge clk);
    chk("dropped_write_len", int'(len), 8);
    step();
    do_clr();
    @(negedge clk);
    chk("clr_len", int'(len), 0);
    step();
    run(1, 0, 0, 0, 0, 1'b0, 2'b00, 1'b1);
    wait_done();

    // Reset at the second ISSUE cycle
    wr(2'b11); wr(2'b01); wr(2'b00);
    run(0, 0, 0, 0, 0, 1'b0, 2'b00, 1'b0);
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_chk_rst", int'(chk_rst), 1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_len", int'(len), 0);
    chk("mid_reset_chk_valid", int'(chk_valid), 0);
    step();
    step();
    run(1, 0, 0, 0, 0, 1'b0, 2'b00, 1'b1);
    wait_done();

    // Write together with start, then a dropped write while busy
    wr(2'b11); wr(2'b01); wr(2'b00);
    run(6, 1, 0, 1, 4, 1'b1, 2'b00, 1'b1);
    wr_en  = 1'b1;
    wr_sym = 2'b10;
    step();
    wr_en  = 1'b0;
    @(negedge clk);
    chk("busy_write_len", int'(len), 4);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
